seg7_score_readback: RTL
========================

// Module: seg7_score_readback
// PURPOSE
//  Receive side of the two-digit tally display interface. Takes the active-low 7-segment
//  lines of both digits (tens = high nibble, units = low nibble, hex glyphs), waits for a
//  stable pattern, decodes it back to an 8-bit score and flags illegal glyphs.
//  Used for on-board self-check and loopback of the tally display path.
// PARAMETERS
//  STABLE_CYCLES  250  consecutive identical samples required before acceptance (min 2)
// PORTS
//  i_Clk         in   1  system clock
//  i_Rst_L       in   1  asynchronous active-low reset
//  i_Seg1_N      in   7  digit 1 (high nibble) segments {A,B,C,D,E,F,G}, bit6=A, active-low
//  i_Seg2_N      in   7  digit 2 (low nibble) segments, same order/polarity
//  o_Score       out  8  last accepted score {digit1, digit2}
//  o_Valid       out  1  1-cycle pulse when o_Score takes a new value
//  o_Error       out  1  level: last stable pattern contained an illegal glyph
//  o_Inc/o_Dec/o_Clr/o_Jump  out 1 each  delta pulses (only with SEG_READBACK_DELTA_EN)
// BEHAVIOUR
//  - Clock i_Clk; reset i_Rst_L is asynchronous, active-low. All state clears on assert.
//  - Reset values: o_Score=8'h00, o_Valid=0, o_Error=0, delta pulses 0, candidate=14'h3FFF
//    (all segments off), stability counter=0, state=S_WAIT, have-score flag=0.
//  - Inputs registered once (r_Sample). Each cycle r_Sample compared with r_Cand:
//    mismatch -> r_Cand<=r_Sample, count<=0, state S_WAIT (restart, also from S_LOCKED).
//    match in S_WAIT -> count++; at count==STABLE_CYCLES-1 perform acceptance, go S_LOCKED.
//    S_LOCKED holds (count saturates) until next mismatch.
//  - Glyph table (active-high after inversion): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
//    8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. Any other code (incl. blank 00) is illegal.
//  - Acceptance: both glyphs legal -> o_Error<=0; if have-flag=0 or decoded!=o_Score:
//    o_Score<=decoded, o_Valid pulse, have<=1. Same value re-accepted -> no pulse.
//    Any glyph illegal -> o_Error<=1, o_Score and have unchanged, no pulse.
//  - Latency: pattern stable at pins from clock edge t -> o_Valid high in cycle
//    t+STABLE_CYCLES+2 (1 input reg, 1 candidate load, STABLE_CYCLES-1 counts, 1 output reg).
//  - A pattern changing before the count completes is never accepted; glitches shorter
//    than STABLE_CYCLES produce no output activity.
//  - Reset mid-count discards candidate; first acceptance after reset always pulses o_Valid.
// CONFIGURATION
//  SEG_READBACK_DELTA_EN defined: on every o_Valid with have=1 before acceptance, exactly one
//   of: o_Inc if new==old+1; o_Dec if new==old-1; else o_Clr if new==0; else o_Jump.
//   No wrap: 8'hFF->8'h00 is o_Clr, 8'h00->8'hFF is o_Jump. First acceptance after reset:
//   no delta pulse. Pulses coincide with o_Valid.
//  Not defined: delta ports still present, tied to 0; no comparison logic built.
// STRUCTURE
//  - seg7_pkg: glyph constants SEG7_GLYPH_0..F, state enum {S_WAIT,S_LOCKED}, SEG7_BLANK.
//  - Sub-module seg7_glyph_decode: comb. 7-bit active-high glyph -> {legal, nibble[3:0]};
//    instantiated twice. Top holds sampler, stability counter, FSM, output/delta regs.
//  - Counter width $clog2(STABLE_CYCLES).
// TESTING (bench uses STABLE_CYCLES=4)
//  1 Reset, drive "4","2" glyphs (~33,~6D) steady -> o_Score=8'h42, o_Valid one pulse at
//    t+6, o_Error=0; hold 20 more cycles -> no further pulse.
//  2 From 8'h42 toggle digit2 to "3" for 2 cycles then back -> no o_Valid, score stays 42.
//  3 Digit1 illegal code 7'h01 active-high, held -> o_Error=1 after 6 cycles, o_Score=42;
//    then legal "43" -> o_Error=0, o_Valid, o_Score=8'h43.
//  4 Assert i_Rst_L low mid-count -> all outputs 0 immediately; steady "00" after release
//    -> o_Valid pulse with o_Score=8'h00.
//  5 DELTA_EN: sequence 10->11->10->00->FF->00 -> Inc, Dec, Clr, Jump, Clr respectively.
//  6 DELTA_EN off: same sequence -> o_Valid pulses only, all delta outputs stay 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the two-digit 7-segment readback path.
//   - SEG7_GLYPH_0 .. SEG7_GLYPH_F : active-high segment codes {A,B,C,D,E,F,G},
//     bit 6 = segment A, for the hex digits 0..F.
//   - SEG7_BLANK : all segments off (active-high view). This is not a legal digit.
//   - SEG7_RAW_ALL_OFF : both digits dark, seen on the active-low pins.
//   - state_e : readback FSM states.
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG7_GLYPH_0 = 7'h7E;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h30;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h6D;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h33;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h5B;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h5F;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h70;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h7B;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h1F;
  localparam logic [6:0] SEG7_GLYPH_C = 7'h4E;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h3D;
  localparam logic [6:0] SEG7_GLYPH_E = 7'h4F;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h47;

  localparam logic [6:0]  SEG7_BLANK       = 7'h00;
  localparam logic [13:0] SEG7_RAW_ALL_OFF = 14'h3FFF;

  typedef enum logic {
    S_WAIT   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational decode of one active-high 7-segment glyph back to a hex nibble.
// Ports:
//   i_glyph  [6:0]  active-high segments {A,B,C,D,E,F,G}, bit 6 = A
//   o_legal         1 when i_glyph is one of the sixteen hex glyphs
//   o_nibble [3:0]  decoded value (0 when the glyph is illegal)
// -----------------------------------------------------------------------------
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_glyph,
  output logic       o_legal,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_legal  = 1'b1;
    o_nibble = 4'h0;
    case (i_glyph)
      SEG7_GLYPH_0: o_nibble = 4'h0;
      SEG7_GLYPH_1: o_nibble = 4'h1;
      SEG7_GLYPH_2: o_nibble = 4'h2;
      SEG7_GLYPH_3: o_nibble = 4'h3;
      SEG7_GLYPH_4: o_nibble = 4'h4;
      SEG7_GLYPH_5: o_nibble = 4'h5;
      SEG7_GLYPH_6: o_nibble = 4'h6;
      SEG7_GLYPH_7: o_nibble = 4'h7;
      SEG7_GLYPH_8: o_nibble = 4'h8;
      SEG7_GLYPH_9: o_nibble = 4'h9;
      SEG7_GLYPH_A: o_nibble = 4'hA;
      SEG7_GLYPH_B: o_nibble = 4'hB;
      SEG7_GLYPH_C: o_nibble = 4'hC;
      SEG7_GLYPH_D: o_nibble = 4'hD;
      SEG7_GLYPH_E: o_nibble = 4'hE;
      SEG7_GLYPH_F: o_nibble = 4'hF;
      default:      o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_score_readback.sv
// -----------------------------------------------------------------------------
// seg7_score_readback
// Receive side of the two-digit tally display. It samples the active-low segment
// lines of both digits and waits until the pattern has been steady for
// STABLE_CYCLES samples. It then decodes the pattern back to an 8-bit score and
// flags illegal glyphs.
// Ports:
//   i_Clk, i_Rst_L            clock, asynchronous active-low reset
//   i_Seg1_N [6:0]            tens digit (high nibble) segments, active-low
//   i_Seg2_N [6:0]            units digit (low nibble) segments, active-low
//   o_Score  [7:0]            last accepted score {digit1, digit2}
//   o_Valid                   one-cycle pulse when o_Score takes a new value
//   o_Error                   last stable pattern held an illegal glyph
//   o_Inc/o_Dec/o_Clr/o_Jump  change classification, pulsed with o_Valid
// Configuration macro: SEG_READBACK_DELTA_EN enables the delta pulses. Without
// it the delta ports are tied low and no comparison logic is built.
// -----------------------------------------------------------------------------
module seg7_score_readback
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 250
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Seg1_N,
  input  logic [6:0] i_Seg2_N,
  output logic [7:0] o_Score,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Inc,
  output logic       o_Dec,
  output logic       o_Clr,
  output logic       o_Jump
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [13:0]      sample_q, sample_d;
  logic [13:0]      cand_q, cand_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             have_q, have_d;

  logic       legal1, legal2;
  logic [3:0] nib1, nib2;
  logic [7:0] decoded;
  logic       accept;
  logic       take_new;

  // Decoding from the candidate is safe because the candidate equals the sample
  // whenever acceptance fires.
  seg7_glyph_decode u_dec_hi (
    .i_glyph  (~cand_q[13:7]),
    .o_legal  (legal1),
    .o_nibble (nib1)
  );

  seg7_glyph_decode u_dec_lo (
    .i_glyph  (~cand_q[6:0]),
    .o_legal  (legal2),
    .o_nibble (nib2)
  );

  assign decoded = {nib1, nib2};

  always_comb begin
    sample_d = {i_Seg1_N, i_Seg2_N};
    cand_d   = cand_q;
    count_d  = count_q;
    state_d  = state_q;
    accept   = 1'b0;

    // Any change restarts the stability window, including from S_LOCKED.
    // In S_LOCKED the counter holds at its final value.
    if (sample_q != cand_q) begin
      cand_d  = sample_q;
      count_d = '0;
      state_d = S_WAIT;
    end else if (state_q == S_WAIT) begin
      if (count_q == CNT_LAST) begin
        accept  = 1'b1;
        state_d = S_LOCKED;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    score_d  = score_q;
    valid_d  = 1'b0;
    error_d  = error_q;
    have_d   = have_q;
    take_new = 1'b0;

    // An illegal pattern leaves the last good score in place. Re-accepting the
    // same value does not pulse o_Valid.
    if (accept) begin
      if (legal1 && legal2) begin
        error_d = 1'b0;
        if (!have_q || (decoded != score_q)) begin
          take_new = 1'b1;
          score_d  = decoded;
          valid_d  = 1'b1;
          have_d   = 1'b1;
        end
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sample_q <= SEG7_RAW_ALL_OFF;
      cand_q   <= SEG7_RAW_ALL_OFF;
      count_q  <= '0;
      state_q  <= S_WAIT;
      score_q  <= 8'h00;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      have_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      state_q  <= state_d;
      score_q  <= score_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      have_q   <= have_d;
    end
  end

  assign o_Score = score_q;
  assign o_Valid = valid_q;
  assign o_Error = error_q;

`ifdef SEG_READBACK_DELTA_EN
  logic inc_q, inc_d;
  logic dec_q, dec_d;
  logic clr_q, clr_d;
  logic jump_q, jump_d;

  // Comparisons are done 9 bits wide so FF->00 and 00->FF never count as +/-1.
  always_comb begin
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    clr_d  = 1'b0;
    jump_d = 1'b0;
    if (take_new && have_q) begin
      if ({1'b0, decoded} == ({1'b0, score_q} + 9'd1)) begin
        inc_d = 1'b1;
      end else if (({1'b0, decoded} + 9'd1) == {1'b0, score_q}) begin
        dec_d = 1'b1;
      end else if (decoded == 8'h00) begin
        clr_d = 1'b1;
      end else begin
        jump_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      clr_q  <= 1'b0;
      jump_q <= 1'b0;
    end else begin
      inc_q  <= inc_d;
      dec_q  <= dec_d;
      clr_q  <= clr_d;
      jump_q <= jump_d;
    end
  end

  assign o_Inc  = inc_q;
  assign o_Dec  = dec_q;
  assign o_Clr  = clr_q;
  assign o_Jump = jump_q;
`else
  assign o_Inc  = 1'b0;
  assign o_Dec  = 1'b0;
  assign o_Clr  = 1'b0;
  assign o_Jump = 1'b0;
`endif

endmodule
